// File: rtl/conv_frame_tagger.sv
// conv_frame_tagger: recovers (x,y) of each filtered pixel from the frame-valid
// level, masks border pixels whose 3x3 window was incomplete, optionally
// binarizes, and emits registered pixels with SOF/EOL/EOF markers.
module conv_frame_tagger #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic [11:0] MASK_VAL = 12'h000,
  parameter int unsigned XW       = $clog2(H_ACTIVE),
  parameter int unsigned YW       = $clog2(V_ACTIVE)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [11:0]   iPIX12,
  input  logic          iDVAL,
  input  logic          iFVAL,
  input  logic          iTHRESH_EN,
  input  logic [11:0]   iTHRESH,
  output logic [11:0]   oPIX12,
  output logic          oDVAL,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic          oSOF,
  output logic          oEOL,
  output logic          oEOF,
  output logic          oERR
);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e        state_q, state_d;
  logic          fval_q;
  logic [XW-1:0] cnt_x_q, cnt_x_d;
  logic [YW-1:0] cnt_y_q, cnt_y_d;

  logic [11:0]   opix_q, opix_d;
  logic          odval_q, odval_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic          osof_q, osof_d;
  logic          oeol_q, oeol_d;
  logic          oeof_q, oeof_d;
  logic          oerr_q, oerr_d;

  logic          rise;
  logic          accept;
  logic          x_last;
  logic          y_last;
  logic          border;
  logic [11:0]   pix_t;

  assign rise   = iFVAL & ~fval_q;
  assign x_last = (cnt_x_q == XW'(H_ACTIVE - 1));
  assign y_last = (cnt_y_q == YW'(V_ACTIVE - 1));
  // Columns 0/1 see the line-buffer wrap, rows 0/1 see unfilled rows.
  assign border = (32'(cnt_x_q) < 32'd2) || (32'(cnt_y_q) < 32'd2);

  // Threshold (unsigned) applied before the border mask so the mask wins.
  always_comb begin
    pix_t = iPIX12;
    if (iTHRESH_EN) begin
      pix_t = (iPIX12 >= iTHRESH) ? 12'hFFF : 12'h000;
    end
  end

  // Framing FSM, position counters and next-state of the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    accept  = 1'b0;
    oerr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StActive;
          accept  = iDVAL;
        end
      end
      StActive: begin
        if (!iFVAL) begin
          // Short frame: drop any coincident beat and restart on next rise.
          oerr_d  = 1'b1;
          cnt_x_d = '0;
          cnt_y_d = '0;
          state_d = StIdle;
        end else begin
          accept = iDVAL;
        end
      end
      StDone: begin
        if (!iFVAL) begin
          state_d = StIdle;
        end else if (iDVAL) begin
          oerr_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (x_last) begin
        cnt_x_d = '0;
        if (y_last) begin
          cnt_y_d = '0;
          state_d = StDone;
        end else begin
          cnt_y_d = cnt_y_q + 1'b1;
        end
      end else begin
        cnt_x_d = cnt_x_q + 1'b1;
      end
    end

    // Pixel/position hold their last value between beats; markers do not.
    opix_d  = opix_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    odval_d = 1'b0;
    osof_d  = 1'b0;
    oeol_d  = 1'b0;
    oeof_d  = 1'b0;
    if (accept) begin
      opix_d  = border ? MASK_VAL : pix_t;
      ox_d    = cnt_x_q;
      oy_d    = cnt_y_q;
      odval_d = 1'b1;
      osof_d  = (cnt_x_q == '0) && (cnt_y_q == '0);
      oeol_d  = x_last;
      oeof_d  = x_last && y_last;
    end
  end

  // State and output registers; fval_q resets high so a frame in flight is skipped.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= StIdle;
      fval_q  <= 1'b1;
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      opix_q  <= '0;
      odval_q <= 1'b0;
      ox_q    <= '0;
      oy_q    <= '0;
      osof_q  <= 1'b0;
      oeol_q  <= 1'b0;
      oeof_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFVAL;
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      opix_q  <= opix_d;
      odval_q <= odval_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      osof_q  <= osof_d;
      oeol_q  <= oeol_d;
      oeof_q  <= oeof_d;
      oerr_q  <= oerr_d;
    end
  end

  assign oPIX12 = opix_q;
  assign oDVAL  = odval_q;
  assign oX     = ox_q;
  assign oY     = oy_q;
  assign oSOF   = osof_q;
  assign oEOL   = oeol_q;
  assign oEOF   = oeof_q;
  assign oERR   = oerr_q;

endmodule

// File: tb/tb_conv_frame_tagger.sv
// Bench for conv_frame_tagger with an 8x4 frame: expected beats are queued as
// stimulus is driven and popped when the DUT raises oDVAL.
module tb_conv_frame_tagger;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;

  logic        clk = 1'b0;
  logic        iRST;
  logic [11:0] iPIX12;
  logic        iDVAL;
  logic        iFVAL;
  logic        iTHRESH_EN;
  logic [11:0] iTHRESH;
  logic [11:0] oPIX12;
  logic        oDVAL;
  logic [2:0]  oX;
  logic [1:0]  oY;
  logic        oSOF;
  logic        oEOL;
  logic        oEOF;
  logic        oERR;

  conv_frame_tagger #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .MASK_VAL (12'h000)
  ) dut (
    .iCLK       (clk),
    .iRST       (iRST),
    .iPIX12     (iPIX12),
    .iDVAL      (iDVAL),
    .iFVAL      (iFVAL),
    .iTHRESH_EN (iTHRESH_EN),
    .iTHRESH    (iTHRESH),
    .oPIX12     (oPIX12),
    .oDVAL      (oDVAL),
    .oX         (oX),
    .oY         (oY),
    .oSOF       (oSOF),
    .oEOL       (oEOL),
    .oEOF       (oEOF),
    .oERR       (oERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pix;
    int          x;
    int          y;
    logic        sof;
    logic        eol;
    logic        eof;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          err_cnt = 0;
  int          cyc = 0;
  int          e0;
  logic        th_en = 1'b0;
  logic [11:0] th = 12'h000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Output monitor: compare each oDVAL beat against the head of the queue.
  always @(negedge clk) begin
    if (!iRST) begin
      if (oERR) err_cnt++;
      if (oDVAL) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dval", 32'(oDVAL), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pix", 32'(oPIX12), 32'(e.pix));
          check("x", 32'(oX), e.x);
          check("y", 32'(oY), e.y);
          check("sof", 32'(oSOF), 32'(e.sof));
          check("eol", 32'(oEOL), 32'(e.eol));
          check("eof", 32'(oEOF), 32'(e.eof));
          check("latency_cycle", cyc, e.cyc);
        end
      end else begin
        check("idle_markers", 32'({oSOF, oEOL, oEOF}), 32'd0);
      end
    end
  end

  task automatic idle(input logic fval, input logic dval, input int n);
    iFVAL = fval;
    iDVAL = dval;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input int x, input int y, input logic [11:0] pix);
    exp_t        e;
    logic [11:0] t;
    t     = th_en ? ((pix >= th) ? 12'hFFF : 12'h000) : pix;
    e.pix = (x < 2 || y < 2) ? 12'h000 : t;
    e.x   = x;
    e.y   = y;
    e.sof = (x == 0 && y == 0);
    e.eol = (x == H - 1);
    e.eof = (x == H - 1 && y == V - 1);
    e.cyc = cyc + 1;
    exp_q.push_back(e);
    iFVAL      = 1'b1;
    iDVAL      = 1'b1;
    iPIX12     = pix;
    iTHRESH_EN = th_en;
    iTHRESH    = th;
    @(posedge clk);
    #1;
  endtask

  // mode 0: constant 12'h123; mode 1: alternating 7FF/800.
  task automatic frame(input int nbeats, input int gap, input int mode);
    for (int i = 0; i < nbeats; i++) begin
      logic [11:0] p;
      if (gap > 0) idle(1'b1, 1'b0, gap);
      p = (mode == 0) ? 12'h123 : ((i % 2) == 1 ? 12'h800 : 12'h7FF);
      beat(i % H, i / H, p);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix"}, 32'(oPIX12), 32'd0);
    check({tag, "_dval"}, 32'(oDVAL), 32'd0);
    check({tag, "_x"}, 32'(oX), 32'd0);
    check({tag, "_y"}, 32'(oY), 32'd0);
    check({tag, "_markers"}, 32'({oSOF, oEOL, oEOF, oERR}), 32'd0);
  endtask

  initial begin
    iRST       = 1'b1;
    iPIX12     = '0;
    iDVAL      = 1'b0;
    iFVAL      = 1'b0;
    iTHRESH_EN = 1'b0;
    iTHRESH    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    iRST = 1'b0;
    idle(1'b0, 1'b0, 2);

    // Continuous full frame, threshold off.
    e0 = err_cnt;
    frame(32, 0, 0);
    idle(1'b0, 1'b0, 3);
    check("full_frame_drained", exp_q.size(), 0);
    check("full_frame_no_err", err_cnt - e0, 0);

    // Binarize with threshold 0x800.
    th_en = 1'b1;
    th    = 12'h800;
    frame(32, 0, 1);
    idle(1'b0, 1'b0, 3);
    th_en = 1'b0;
    check("thresh_frame_drained", exp_q.size(), 0);

    // iDVAL 1 of every 3 cycles.
    e0 = err_cnt;
    frame(32, 2, 0);
    idle(1'b0, 1'b0, 3);
    check("gap_frame_drained", exp_q.size(), 0);
    check("gap_frame_no_err", err_cnt - e0, 0);

    // Short frame then a normal frame.
    e0 = err_cnt;
    frame(20, 0, 0);
    idle(1'b0, 1'b0, 3);
    check("short_frame_err", err_cnt - e0, 1);
    frame(32, 0, 0);
    idle(1'b0, 1'b0, 3);
    check("after_short_drained", exp_q.size(), 0);
    check("after_short_err", err_cnt - e0, 1);

    // Long frame: 3 extra beats after EOF.
    e0 = err_cnt;
    frame(32, 0, 0);
    idle(1'b1, 1'b1, 3);
    idle(1'b0, 1'b0, 3);
    check("long_frame_err", err_cnt - e0, 3);
    check("long_frame_drained", exp_q.size(), 0);

    // Reset mid-frame with iFVAL held high.
    frame(20, 0, 0);
    idle(1'b1, 1'b0, 1);
    check("pre_reset_drained", exp_q.size(), 0);
    iRST  = 1'b1;
    iDVAL = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    iRST = 1'b0;
    e0   = err_cnt;
    idle(1'b1, 1'b1, 5);
    idle(1'b0, 1'b0, 2);
    check("post_reset_no_err", err_cnt - e0, 0);
    frame(32, 0, 0);
    idle(1'b0, 1'b0, 3);
    check("post_reset_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_frame_tagger.md
# conv_frame_tagger

Downstream stage of the 3x3 convolution filter. It consumes the filter's 12-bit pixel stream and valid strobe, and recovers each pixel's column/row position from the frame-valid level. It masks border pixels whose 3x3 window was not fully populated, optionally binarizes against a threshold, and emits registered pixels with start/end-of-line/frame markers for the display/VGA writer.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line (must match the filter's line-buffer length)
- V_ACTIVE, 480, lines per frame
- MASK_VAL, 12'h000, value substituted for masked border pixels
- XW, $clog2(H_ACTIVE), width of oX
- YW, $clog2(V_ACTIVE), width of oY

Ports:
- iCLK  in  1  single clock, all logic rising-edge
- iRST  in  1  reset, asynchronous, active-high
- iPIX12  in  12  filtered pixel from the convolution stage
- iDVAL  in  1  pixel valid from the convolution stage
- iFVAL  in  1  frame-valid level from the capture path, high for the whole active frame
- iTHRESH_EN  in  1  1 = binarize output
- iTHRESH  in  12  binarize threshold, unsigned
- oPIX12  out  12  tagged output pixel
- oDVAL  out  1  output valid
- oX  out  XW  column of the current output beat
- oY  out  YW  row of the current output beat
- oSOF  out  1  first beat of frame (x=0, y=0)
- oEOL  out  1  last beat of a line (x=H_ACTIVE-1)
- oEOF  out  1  last beat of frame (x=H_ACTIVE-1, y=V_ACTIVE-1)
- oERR  out  1  one-cycle pulse on framing error

## Operation
- fval_d is iFVAL registered. A rise is iFVAL=1 with fval_d=0.
- FSM states:
  - IDLE: on a rise, go to ACTIVE; an iDVAL in the same cycle is accepted as (0,0). Otherwise iDVAL is dropped silently.
  - ACTIVE: each iDVAL beat is accepted at the current (x,y). After the beat, x increments; at x=H_ACTIVE-1, x wraps to 0 and y increments. The beat at (H_ACTIVE-1, V_ACTIVE-1) moves the FSM to DONE.
    - iFVAL=0 in ACTIVE (short frame): oERR pulses, counters clear, FSM goes to IDLE. A simultaneous iDVAL beat is dropped.
  - DONE: wait for iFVAL=0, then go to IDLE.
    - iDVAL in DONE (long frame): the beat is dropped and oERR pulses, once per extra beat.
    - A rise is impossible in DONE; iFVAL must fall first.
- Pixel path for an accepted beat:
  - If iTHRESH_EN: t = (iPIX12 >= iTHRESH) ? 12'hFFF : 12'h000; else t = iPIX12. Comparison is unsigned.
  - Border mask: if x<2 or y<2, output MASK_VAL. The window of such beats spans the line-buffer wrap or unfilled rows. The mask overrides the threshold.
- Markers are asserted only together with oDVAL, on the beat they describe. A 1x1-position beat can carry oEOL and oEOF together.
- iTHRESH_EN and iTHRESH are sampled per beat. Mid-frame changes take effect on the next accepted beat.

## Timing
- Latency: 1 cycle, from accepted iDVAL beat to oDVAL with its oPIX12/oX/oY/markers. Outputs are registered.
- oDVAL is high only in cycles following an accepted beat; no back-pressure exists. Gaps in iDVAL pass through unchanged.
- When oDVAL=0:
  - oSOF/oEOL/oEOF are 0.
  - oPIX12/oX/oY hold their last value.
- oERR is registered and asserts the cycle after the offending condition.
- Reset (async, any time including mid-frame): FSM goes to IDLE and counters go to 0.
  - fval_d resets to 1, so a frame in progress at reset release is skipped until iFVAL falls and rises again.
  - All outputs reset to 0: oPIX12=0, oDVAL=0, oX=0, oY=0, oSOF=oEOL=oEOF=oERR=0.

## Test plan
Use H_ACTIVE=8, V_ACTIVE=4, MASK_VAL=0.
- Full frame, continuous iDVAL, iPIX12=12'h123, thresholding off -> 32 oDVAL beats.
  - Beats with x<2 or y<2 output 0; the other 12 beats output 12'h123.
  - oSOF on beat 0, oEOL on beats 7/15/23/31, oEOF on beat 31, oERR never.
- iTHRESH_EN=1, iTHRESH=12'h800, pixels alternating 12'h7FF/12'h800 -> interior beats output 000/FFF alternately; border beats still 0.
- iDVAL high 1 of every 3 cycles -> oDVAL mirrors the input pattern delayed by exactly 1 cycle; positions identical to the continuous case.
- iFVAL falls after 20 beats -> oERR pulses once, FSM returns to IDLE; the next frame starts at (0,0) with oSOF.
- 3 extra iDVAL beats after oEOF while iFVAL still high -> no oDVAL, 3 oERR pulses.
- iRST asserted mid-frame (iFVAL held high), then released -> all outputs 0; no oDVAL until iFVAL toggles low then high; the next frame is tagged correctly from (0,0).
